// File: rtl/tbec_scrubber.sv
// Host/scrub arbiter for an ECC-protected memory: serves host accesses and periodically
// scrubs one word, writing back corrected data. Statistics counters exist only with TBEC_SCRUB_STATS_EN.
`timescale 1ns/1ps

module tbec_scrubber #(
  parameter int NUM_WORDS      = 8,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic [1:0]  host_err,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic [1:0]  mem_err,
  input  logic        scrub_en,
  input  logic        irq_clr,
  output logic        uncorr_irq,
  output logic [15:0] corr_count,
  output logic [15:0] uncorr_count
);

  localparam int             CW        = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [CW-1:0]  INTV_MAX  = CW'(SCRUB_INTERVAL - 1);
  localparam logic [7:0]     PTR_MAX   = 8'(NUM_WORDS - 1);
  localparam logic [8:0]     NUM_WORDS_W = 9'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOST      = 2'd1,
    SCRUB_CHK = 2'd2,
    SCRUB_FIX = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic          cap_we_r, cap_we_s;
  logic [7:0]    cap_addr_r, cap_addr_s;
  logic [7:0]    scrub_ptr_r, scrub_ptr_s;
  logic [CW-1:0] intv_r, intv_s;
  logic          host_ack_r, host_ack_s;
  logic [15:0]   host_rdata_r, host_rdata_s;
  logic [1:0]    host_err_r, host_err_s;
  logic [7:0]    mem_addr_r, mem_addr_s;
  logic [15:0]   mem_wdata_r, mem_wdata_s;
  logic          mem_we_r, mem_we_s;
  logic          uncorr_irq_r, uncorr_irq_s;
  logic          uncorr_set_s;

  function automatic logic [7:0] ptr_next(input logic [7:0] p);
    if (p >= PTR_MAX) begin
      return 8'd0;
    end else begin
      return p + 8'd1;
    end
  endfunction

  function automatic logic addr_ok(input logic [7:0] a);
    return ({1'b0, a} < NUM_WORDS_W);
  endfunction

  // Next-state, datapath and next memory-port values (memory port is registered)
  always_comb begin
    state_s      = state_r;
    cap_we_s     = cap_we_r;
    cap_addr_s   = cap_addr_r;
    scrub_ptr_s  = scrub_ptr_r;
    intv_s       = intv_r;
    host_ack_s   = 1'b0;
    host_rdata_s = host_rdata_r;
    host_err_s   = host_err_r;
    mem_addr_s   = 8'd0;
    mem_wdata_s  = 16'd0;
    mem_we_s     = 1'b0;
    uncorr_set_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (scrub_en && (intv_r != INTV_MAX)) begin
          intv_s = intv_r + CW'(1);
        end else begin
          intv_s = intv_r;
        end
        if (host_req && !host_ack_r) begin
          state_s    = HOST;
          cap_we_s   = host_we;
          cap_addr_s = host_addr;
          mem_addr_s = host_addr;
          if (host_we && addr_ok(host_addr)) begin
            mem_we_s    = 1'b1;
            mem_wdata_s = host_wdata;
          end else begin
            mem_we_s    = 1'b0;
          end
        end else if (scrub_en && (intv_r == INTV_MAX)) begin
          state_s    = SCRUB_CHK;
          intv_s     = {CW{1'b0}};
          mem_addr_s = scrub_ptr_r;
        end else begin
          state_s = IDLE;
        end
      end
      HOST: begin
        state_s    = IDLE;
        host_ack_s = 1'b1;
        if (!addr_ok(cap_addr_r)) begin
          host_rdata_s = 16'd0;
          host_err_s   = 2'b11;
        end else if (cap_we_r) begin
          host_rdata_s = 16'd0;
          host_err_s   = 2'b00;
        end else begin
          host_rdata_s = mem_rdata;
          host_err_s   = mem_err[1] ? 2'b10 : mem_err;
        end
      end
      SCRUB_CHK: begin
        case (mem_err)
          2'b00: begin
            scrub_ptr_s = ptr_next(scrub_ptr_r);
            state_s     = IDLE;
          end
          2'b01: begin
            state_s     = SCRUB_FIX;
            mem_we_s    = 1'b1;
            mem_addr_s  = scrub_ptr_r;
            mem_wdata_s = mem_rdata;
          end
          default: begin
            uncorr_set_s = 1'b1;
            scrub_ptr_s  = ptr_next(scrub_ptr_r);
            state_s      = IDLE;
          end
        endcase
      end
      SCRUB_FIX: begin
        scrub_ptr_s = ptr_next(scrub_ptr_r);
        state_s     = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // A new uncorrectable error outranks a clear in the same cycle
    if (uncorr_set_s) begin
      uncorr_irq_s = 1'b1;
    end else if (irq_clr) begin
      uncorr_irq_s = 1'b0;
    end else begin
      uncorr_irq_s = uncorr_irq_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cap_we_r     <= 1'b0;
      cap_addr_r   <= 8'd0;
      scrub_ptr_r  <= 8'd0;
      intv_r       <= {CW{1'b0}};
      host_ack_r   <= 1'b0;
      host_rdata_r <= 16'd0;
      host_err_r   <= 2'b00;
      mem_addr_r   <= 8'd0;
      mem_wdata_r  <= 16'd0;
      mem_we_r     <= 1'b0;
      uncorr_irq_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cap_we_r     <= cap_we_s;
      cap_addr_r   <= cap_addr_s;
      scrub_ptr_r  <= scrub_ptr_s;
      intv_r       <= intv_s;
      host_ack_r   <= host_ack_s;
      host_rdata_r <= host_rdata_s;
      host_err_r   <= host_err_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      mem_we_r     <= mem_we_s;
      uncorr_irq_r <= uncorr_irq_s;
    end
  end

  assign host_ack   = host_ack_r;
  assign host_rdata = host_rdata_r;
  assign host_err   = host_err_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_we     = mem_we_r;
  assign uncorr_irq = uncorr_irq_r;

`ifdef TBEC_SCRUB_STATS_EN
  logic [15:0] corr_count_r, uncorr_count_r;
  logic        corr_inc_s, uncorr_inc_s;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Scrub event decode for the statistics counters
  always_comb begin
    corr_inc_s   = 1'b0;
    uncorr_inc_s = 1'b0;
    if (state_r == SCRUB_FIX) begin
      corr_inc_s = 1'b1;
    end else begin
      corr_inc_s = 1'b0;
    end
    if ((state_r == SCRUB_CHK) && mem_err[1]) begin
      uncorr_inc_s = 1'b1;
    end else begin
      uncorr_inc_s = 1'b0;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_count_r   <= 16'd0;
      uncorr_count_r <= 16'd0;
    end else begin
      if (corr_inc_s) begin
        corr_count_r <= sat_inc16(corr_count_r);
      end
      if (uncorr_inc_s) begin
        uncorr_count_r <= sat_inc16(uncorr_count_r);
      end
    end
  end

  assign corr_count   = corr_count_r;
  assign uncorr_count = uncorr_count_r;
`else
  assign corr_count   = 16'd0;
  assign uncorr_count = 16'd0;
`endif

endmodule

// File: doc/tbec_scrubber.md
TBEC_SCRUBBER -- requirements
Module: tbec_scrubber

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 8: number of protected memory words; valid addresses are 0..NUM_WORDS-1.
REQ-002 SHALL have parameter SCRUB_INTERVAL, default 1024: number of idle cycles between scrub accesses.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports host_req in 1, host_we in 1, host_addr in 8, host_wdata in 16: host request; request held high until acknowledged.
REQ-006 SHALL have ports host_ack out 1, host_rdata out 16, host_err out 2: one-cycle completion pulse with read data and status.
REQ-007 SHALL have ports mem_addr out 8, mem_wdata out 16, mem_we out 1: drive the ECC memory's address, write-data and write-enable.
REQ-008 SHALL have ports mem_rdata in 16, mem_err in 2: ECC memory decoded data and error code, combinational from mem_addr.
REQ-009 SHALL have ports scrub_en in 1, irq_clr in 1, uncorr_irq out 1, corr_count out 16, uncorr_count out 16.

Function
REQ-010 SHALL interpret the memory error code as: 00 clean, 01 single-bit corrected, 10 uncorrectable, 11 treated as 10.
REQ-011 SHALL implement FSM states IDLE, HOST, SCRUB_CHK, SCRUB_FIX; each non-IDLE state lasts exactly one cycle.
REQ-012 SHALL, in IDLE with host_req=1 and host_ack=0, capture host_we/addr/wdata and go to HOST; host has priority over scrub.
REQ-013 SHALL, in HOST, drive mem_addr from the captured address; when writing, assert mem_we with mem_wdata = captured data; when reading, register mem_rdata/mem_err into host_rdata/host_err.
REQ-014 SHALL assert host_ack for exactly one cycle, the cycle after HOST: 2 cycles from request sample to ack; host_err=00 on writes.
REQ-015 SHALL, for a captured address >= NUM_WORDS, suppress mem_we and complete with host_err=11 and host_rdata=0.
REQ-016 SHALL count IDLE cycles while scrub_en=1, saturating at SCRUB_INTERVAL-1; when saturated and no host request is accepted that cycle, go to SCRUB_CHK and clear the counter.
REQ-017 SHALL, in SCRUB_CHK, drive mem_addr=scrub_ptr and sample mem_err: 00 -> increment ptr, go to IDLE; 01 -> latch mem_rdata, go to SCRUB_FIX; 10/11 -> increment uncorr_count, set uncorr_irq, increment ptr, go to IDLE.
REQ-018 SHALL, in SCRUB_FIX, assert mem_we with mem_addr=scrub_ptr and mem_wdata=latched data, increment corr_count and ptr, then go to IDLE.
REQ-019 SHALL wrap scrub_ptr from NUM_WORDS-1 to 0.
REQ-020 SHALL saturate corr_count and uncorr_count at 16'hFFFF.
REQ-021 SHALL keep uncorr_irq sticky until irq_clr=1; a simultaneous set and clear SHALL leave it set.
REQ-022 SHALL drive mem_we=0 in IDLE and in reads; mem_addr=0 in IDLE.
REQ-023 SHALL hold the interval counter without clearing when scrub_en falls.

Reset
REQ-024 SHALL on rst: FSM to IDLE; host_ack, host_rdata, host_err, mem_we, uncorr_irq, scrub_ptr, interval counter, corr_count, and uncorr_count all 0.
REQ-025 SHALL, on reset mid-operation, abandon the transaction without asserting host_ack or mem_we in the following cycle.

Configuration
REQ-026 SHALL, with TBEC_SCRUB_STATS_EN defined, implement corr_count and uncorr_count as specified.
REQ-027 SHALL, without TBEC_SCRUB_STATS_EN, tie corr_count and uncorr_count to 0; all other behaviour, including uncorr_irq, stays unchanged.

Verification
REQ-028 SHALL cover: host write addr 3 data 16'hA5A5 then read addr 3 -> ack 2 cycles after each request, host_rdata=16'hA5A5, host_err=00.
REQ-029 SHALL cover: mem_err forced 01 at addr 5, SCRUB_INTERVAL=4 -> SCRUB_FIX writes mem_rdata back to addr 5, corr_count=1, ptr=6.
REQ-030 SHALL cover: mem_err forced 10 at scrub addr -> uncorr_count=1, uncorr_irq=1; irq_clr in the same cycle as a new error -> irq stays 1.
REQ-031 SHALL cover: host_req in the same cycle the scrub interval expires -> HOST first, SCRUB_CHK in the next IDLE cycle; ptr wraps 7->0.
REQ-032 SHALL cover: host write to addr 8 -> mem_we never asserted, host_err=11; rst asserted in HOST -> no host_ack, all outputs 0.
